// File: rtl/imuldiv_div_frontend_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imuldiv_div_frontend_pkg - divide fn codes, divider fn, FIFO tag type  |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
package imuldiv_div_frontend_pkg;

  typedef enum logic [1:0] {
    IMULDIV_DIVFN_DIV  = 2'd0,
    IMULDIV_DIVFN_DIVU = 2'd1,
    IMULDIV_DIVFN_REM  = 2'd2,
    IMULDIV_DIVFN_REMU = 2'd3
  } divfn_e;

  localparam logic        IMULDIV_DIVREQ_SIGNED   = 1'b1;
  localparam logic        IMULDIV_DIVREQ_UNSIGNED = 1'b0;
  localparam logic [31:0] IMULDIV_DIVZERO_QUOT    = 32'hFFFF_FFFF;

  typedef struct packed {
    logic        bypass;
    logic        rem_sel;
    logic [31:0] data;
  } divtag_t;

  // Divide-by-zero result: all-ones quotient, dividend as remainder.
  function automatic logic [31:0] bypass_data(input divfn_e fn, input logic [31:0] dividend);
    logic [31:0] data;
    data = IMULDIV_DIVZERO_QUOT;
    case (fn)
      IMULDIV_DIVFN_REM, IMULDIV_DIVFN_REMU: data = dividend;
      default:                               data = IMULDIV_DIVZERO_QUOT;
    endcase
    return data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/imuldiv_div_frontend_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imuldiv_div_frontend_if - issue-side and divider-side handshakes        |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
interface imuldiv_div_frontend_if;

  logic        req_val;
  logic        req_rdy;
  logic [1:0]  req_msg_fn;
  logic [31:0] req_msg_a;
  logic [31:0] req_msg_b;

  logic        divreq_val;
  logic        divreq_rdy;
  logic        divreq_msg_fn;
  logic [31:0] divreq_msg_a;
  logic [31:0] divreq_msg_b;

  logic        divresp_val;
  logic        divresp_rdy;
  logic [63:0] divresp_msg_result;

  logic        resp_val;
  logic        resp_rdy;
  logic [31:0] resp_msg_result;

  modport slave (
    input  req_val, req_msg_fn, req_msg_a, req_msg_b,
    output req_rdy,
    output divreq_val, divreq_msg_fn, divreq_msg_a, divreq_msg_b,
    input  divreq_rdy,
    input  divresp_val, divresp_msg_result,
    output divresp_rdy,
    output resp_val, resp_msg_result,
    input  resp_rdy
  );

  modport master (
    output req_val, req_msg_fn, req_msg_a, req_msg_b,
    input  req_rdy,
    input  divreq_val, divreq_msg_fn, divreq_msg_a, divreq_msg_b,
    output divreq_rdy,
    output divresp_val, divresp_msg_result,
    input  divresp_rdy,
    input  resp_val, resp_msg_result,
    output resp_rdy
  );

endinterface
`default_nettype wire

// File: rtl/imuldiv_tag_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imuldiv_tag_fifo - in-order tag FIFO, wrap-bit pointers plus count     |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module imuldiv_tag_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Same index with differing wrap bits means the write side lapped the read side.
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) begin
      wptr_d = wptr_q + ONE;
    end
    if (do_pop) begin
      rptr_d = rptr_q + ONE;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= push_data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/imuldiv_div_frontend.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imuldiv_div_frontend - divide request decode, div-by-zero bypass, mux  |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module imuldiv_div_frontend
  import imuldiv_div_frontend_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  imuldiv_div_frontend_if.slave  div_if
);

  logic    is_bypass;
  logic    is_signed;
  logic    req_go;
  logic    resp_go;
  logic    fifo_full;
  logic    fifo_empty;
  divtag_t push_tag;
  divtag_t head_tag;

  assign is_bypass = (div_if.req_msg_b == '0);
  assign is_signed = !div_if.req_msg_fn[0];

  // A non-bypass accept and the divider request firing are one event.
  assign div_if.req_rdy    = !fifo_full && (is_bypass || div_if.divreq_rdy);
  assign div_if.divreq_val = div_if.req_val && !fifo_full && !is_bypass;
  assign req_go            = div_if.req_val && div_if.req_rdy;

  assign div_if.divreq_msg_fn = is_signed ? IMULDIV_DIVREQ_SIGNED : IMULDIV_DIVREQ_UNSIGNED;
  assign div_if.divreq_msg_a  = div_if.req_msg_a;
  assign div_if.divreq_msg_b  = div_if.req_msg_b;

  always_comb begin
    push_tag.bypass  = is_bypass;
    push_tag.rem_sel = div_if.req_msg_fn[1];
    push_tag.data    = '0;
    if (is_bypass) begin
      push_tag.data = bypass_data(divfn_e'(div_if.req_msg_fn), div_if.req_msg_a);
    end
  end

  imuldiv_tag_fifo #(
    .WIDTH ($bits(divtag_t)),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (req_go),
    .push_data_i (push_tag),
    .pop_i       (resp_go),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (head_tag)
  );

  // A bypass entry behind a pending divide stays blocked until that divide returns.
  assign div_if.resp_val    = !fifo_empty && (head_tag.bypass || div_if.divresp_val);
  assign div_if.divresp_rdy = !fifo_empty && !head_tag.bypass && div_if.resp_rdy;
  assign resp_go            = div_if.resp_val && div_if.resp_rdy;

  always_comb begin
    div_if.resp_msg_result = div_if.divresp_msg_result[31:0];
    if (head_tag.bypass) begin
      div_if.resp_msg_result = head_tag.data;
    end else if (head_tag.rem_sel) begin
      div_if.resp_msg_result = div_if.divresp_msg_result[63:32];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imuldiv_div_frontend.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_imuldiv_div_frontend - divider model, scoreboard, scenario tasks    |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_imuldiv_div_frontend;

  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   div_lat;

  imuldiv_div_frontend_if bif ();

  imuldiv_div_frontend #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .div_if (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RISC-V divide semantics, returns {remainder, quotient}.
  function automatic logic [63:0] div_compute(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  function automatic logic [31:0] ref_result(input logic [1:0] fn, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] rq;
    if (b == 32'd0) return fn[1] ? a : 32'hFFFF_FFFF;
    rq = div_compute(!fn[0], a, b);
    return fn[1] ? rq[63:32] : rq[31:0];
  endfunction

  typedef struct {
    logic [63:0] res;
    int          due;
  } dentry_t;

  dentry_t     dq[$];
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  bit          s_reset, s_req_fire, s_rsp_fire, s_div_fn;
  logic [31:0] s_div_a, s_div_b;
  int          dcyc;

  // Sample handshakes between clock edges.
  always @(negedge clk) begin
    s_reset    = reset;
    s_req_fire = bif.divreq_val && bif.divreq_rdy;
    s_rsp_fire = bif.divresp_val && bif.divresp_rdy;
    s_div_fn   = bif.divreq_msg_fn;
    s_div_a    = bif.divreq_msg_a;
    s_div_b    = bif.divreq_msg_b;
    if (!reset) begin
      if (bif.req_val && bif.req_rdy)
        exp_q.push_back(ref_result(bif.req_msg_fn, bif.req_msg_a, bif.req_msg_b));
      if (bif.resp_val && bif.resp_rdy)
        obs_q.push_back(bif.resp_msg_result);
    end
  end

  // Behavioural divider: in-order, configurable latency.
  always @(posedge clk) begin
    #1;
    if (s_reset) begin
      dq.delete();
    end else begin
      if (s_rsp_fire && dq.size() > 0) void'(dq.pop_front());
      if (s_req_fire) dq.push_back('{res: div_compute(s_div_fn, s_div_a, s_div_b), due: dcyc + div_lat});
    end
    dcyc++;
    if (dq.size() > 0 && dq[0].due <= dcyc) begin
      bif.divresp_val        = 1'b1;
      bif.divresp_msg_result = dq[0].res;
    end else begin
      bif.divresp_val        = 1'b0;
      bif.divresp_msg_result = 64'd0;
    end
  end

  task automatic send(input logic [1:0] fn, input logic [31:0] a, input logic [31:0] b, output bit ok);
    bif.req_msg_fn = fn;
    bif.req_msg_a  = a;
    bif.req_msg_b  = b;
    bif.req_val    = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (bif.req_rdy) ok = 1'b1;
      @(posedge clk); #1;
    end
    bif.req_val = 1'b0;
  endtask

  task automatic get_resp(output logic [31:0] got, output logic [31:0] exp, output bit ok);
    ok  = 1'b0;
    got = 'x;
    exp = 'x;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk); #2;
      if (obs_q.size() > 0) begin
        got = obs_q.pop_front();
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        ok = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (bif.resp_val !== 1'b0) begin failures++; $display("FAIL reset_resp_val: got %b want 0", bif.resp_val); end
    checks++; if (bif.divresp_rdy !== 1'b0) begin failures++; $display("FAIL reset_divresp_rdy: got %b want 0", bif.divresp_rdy); end
    checks++; if (bif.divreq_val !== 1'b0) begin failures++; $display("FAIL reset_divreq_val: got %b want 0", bif.divreq_val); end
    checks++; if (bif.req_rdy !== 1'b1) begin failures++; $display("FAIL reset_req_rdy: got %b want 1", bif.req_rdy); end
    @(posedge clk); #1;
  endtask

  task automatic test_div_basic();
    logic [31:0] got, exp;
    bit ok;
    div_lat = 3;
    bif.req_msg_fn = 2'd0; bif.req_msg_a = 32'd100; bif.req_msg_b = 32'd7; bif.req_val = 1'b1;
    @(negedge clk);
    checks++; if (bif.divreq_val !== 1'b1) begin failures++; $display("FAIL div_divreq_val: got %b want 1", bif.divreq_val); end
    checks++; if (bif.divreq_msg_fn !== 1'b1) begin failures++; $display("FAIL div_divreq_fn: got %b want 1", bif.divreq_msg_fn); end
    checks++; if (bif.divreq_msg_a !== 32'd100 || bif.divreq_msg_b !== 32'd7) begin
      failures++; $display("FAIL div_divreq_ops: got a=%0d b=%0d want a=100 b=7", bif.divreq_msg_a, bif.divreq_msg_b); end
    @(posedge clk); #1;
    bif.req_val = 1'b0;
    get_resp(got, exp, ok);
    checks++; if (!ok || got !== 32'd14 || exp !== 32'd14) begin failures++; $display("FAIL div_100_7: got %0d want 14", got); end
    send(2'd2, 32'd100, 32'd7, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rem_accept: got timeout want accept"); end
    get_resp(got, exp, ok);
    checks++; if (!ok || got !== 32'd2 || exp !== 32'd2) begin failures++; $display("FAIL rem_100_7: got %0d want 2", got); end
  endtask

  task automatic test_bypass();
    logic [31:0] got, exp;
    bit ok;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      bif.req_msg_fn = (k == 0) ? 2'd1 : 2'd3;
      bif.req_msg_a  = 32'hFFFF_FFFE;
      bif.req_msg_b  = 32'd0;
      bif.req_val    = 1'b1;
      @(negedge clk);
      checks++; if (bif.divreq_val !== 1'b0 || bif.req_rdy !== 1'b1) begin
        failures++; $display("FAIL bypass_req: got divreq_val=%b req_rdy=%b want 0/1", bif.divreq_val, bif.req_rdy); end
      @(posedge clk); #1;
      bif.req_val = 1'b0;
      @(negedge clk);
      exp = (k == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFE;
      checks++; if (bif.resp_val !== 1'b1 || bif.resp_msg_result !== exp) begin
        failures++; $display("FAIL bypass_lat1_%0d: got val=%b data=%h want 1/%h", k, bif.resp_val, bif.resp_msg_result, exp); end
      get_resp(got, exp, ok);
      checks++; if (!ok || got !== exp) begin failures++; $display("FAIL bypass_sb_%0d: got %h want %h", k, got, exp); end
    end
  endtask

  task automatic test_order();
    logic [31:0] got, exp;
    bit ok1, ok2;
    int seen;
    div_lat = 33;
    send(2'd0, 32'd9, 32'd3, ok1);
    send(2'd2, 32'd5, 32'd0, ok2);
    checks++; if (!ok1 || !ok2) begin failures++; $display("FAIL order_accept: got %b%b want 11", ok1, ok2); end
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bif.resp_val) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL order_wait: got %0d early resp want 0", seen); end
    get_resp(got, exp, ok1);
    checks++; if (!ok1 || got !== 32'd3 || exp !== 32'd3) begin failures++; $display("FAIL order_first: got %0d want 3", got); end
    get_resp(got, exp, ok1);
    checks++; if (!ok1 || got !== 32'd5 || exp !== 32'd5) begin failures++; $display("FAIL order_second: got %0d want 5", got); end
    div_lat = 3;
  endtask

  task automatic test_full();
    logic [31:0] got, exp;
    bit ok;
    @(posedge clk); #1;
    bif.resp_rdy = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      bif.req_msg_fn = 2'($urandom_range(0, 3));
      bif.req_msg_a  = $urandom;
      bif.req_msg_b  = 32'd0;
      bif.req_val    = 1'b1;
      @(negedge clk);
      checks++; if (bif.req_rdy !== (i < DEPTH)) begin
        failures++; $display("FAIL fill_rdy_%0d: got %b want %b", i, bif.req_rdy, (i < DEPTH)); end
      @(posedge clk); #1;
    end
    bif.resp_rdy = 1'b1;
    @(negedge clk);
    checks++; if (bif.req_rdy !== 1'b0 || bif.resp_val !== 1'b1) begin
      failures++; $display("FAIL full_pop_no_pass: got rdy=%b val=%b want 0/1", bif.req_rdy, bif.resp_val); end
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      bif.req_msg_fn = 2'($urandom_range(0, 3));
      bif.req_msg_a  = $urandom;
      @(negedge clk);
      checks++; if (bif.req_rdy !== 1'b1 || bif.resp_val !== 1'b1) begin
        failures++; $display("FAIL steady_%0d: got rdy=%b val=%b want 1/1", i, bif.req_rdy, bif.resp_val); end
      @(posedge clk); #1;
    end
    bif.req_val = 1'b0;
    while (exp_q.size() > 0) begin
      get_resp(got, exp, ok);
      checks++; if (!ok || got !== exp) begin failures++; $display("FAIL full_drain: got %h want %h", got, exp); end
      if (!ok) break;
    end
  endtask

  task automatic test_stall();
    logic [31:0] got, exp;
    bit ok;
    @(posedge clk); #1;
    bif.divreq_rdy = 1'b0;
    bif.req_msg_fn = 2'd0; bif.req_msg_a = 32'd50; bif.req_msg_b = 32'd5; bif.req_val = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++; if (bif.req_rdy !== 1'b0 || bif.divreq_val !== 1'b1) begin
        failures++; $display("FAIL stall_div: got rdy=%b divreq_val=%b want 0/1", bif.req_rdy, bif.divreq_val); end
      @(posedge clk); #1;
    end
    bif.req_msg_b = 32'd0;
    @(negedge clk);
    checks++; if (bif.req_rdy !== 1'b1) begin failures++; $display("FAIL stall_bypass_rdy: got %b want 1", bif.req_rdy); end
    @(posedge clk); #1;
    bif.req_val = 1'b0;
    @(negedge clk);
    checks++; if (bif.resp_val !== 1'b1 || bif.resp_msg_result !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL stall_no_push: got val=%b data=%h want 1/ffffffff", bif.resp_val, bif.resp_msg_result); end
    get_resp(got, exp, ok);
    checks++; if (!ok || got !== exp) begin failures++; $display("FAIL stall_sb: got %h want %h", got, exp); end
    bif.divreq_rdy = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] got, exp;
    bit ok;
    div_lat = 20;
    send(2'd1, 32'd1000, 32'd10, ok);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    bif.req_msg_b = 32'd0;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (bif.resp_val !== 1'b0 || bif.divresp_rdy !== 1'b0 || bif.req_rdy !== 1'b1) begin
      failures++; $display("FAIL reset_mid: got val=%b drdy=%b rdy=%b want 0/0/1", bif.resp_val, bif.divresp_rdy, bif.req_rdy); end
    exp_q.delete();
    obs_q.delete();
    div_lat = 2;
    @(posedge clk); #1;
    send(2'd1, 32'd10, 32'd3, ok);
    get_resp(got, exp, ok);
    checks++; if (!ok || got !== 32'd3 || exp !== 32'd3) begin failures++; $display("FAIL reset_then_divu: got %0d want 3", got); end
  endtask

  task automatic test_random();
    localparam int N = 200;
    logic [31:0] got, exp;
    bit ok, pend, acc;
    int sent, r;
    sent = 0; pend = 0; acc = 0;
    for (int cyc = 0; cyc < 5000 && sent < N; cyc++) begin
      @(posedge clk); #1;
      if (pend && acc) begin pend = 0; sent++; bif.req_val = 1'b0; end
      if (!pend && sent < N && $urandom_range(0, 3) != 0) begin
        r = $urandom_range(0, 9);
        bif.req_msg_fn = 2'($urandom_range(0, 3));
        bif.req_msg_a  = (r == 2) ? 32'h8000_0000 : $urandom;
        bif.req_msg_b  = (r < 2) ? 32'd0 : (r == 2) ? 32'hFFFF_FFFF :
                         (r == 3) ? 32'($urandom_range(1, 15)) : $urandom;
        bif.req_val    = 1'b1;
        pend = 1;
      end
      bif.divreq_rdy = ($urandom_range(0, 3) != 0);
      bif.resp_rdy   = ($urandom_range(0, 4) != 0);
      div_lat        = $urandom_range(1, 6);
      @(negedge clk);
      acc = bif.req_val && bif.req_rdy;
      if (bif.req_val && bif.req_msg_b == 32'd0) begin
        checks++; if (bif.divreq_val !== 1'b0) begin failures++; $display("FAIL rnd_bypass_divreq: got %b want 0", bif.divreq_val); end
      end
      if (bif.divreq_val) begin
        checks++; if (bif.divreq_msg_fn !== !bif.req_msg_fn[0] || bif.divreq_msg_a !== bif.req_msg_a || bif.divreq_msg_b !== bif.req_msg_b) begin
          failures++; $display("FAIL rnd_divreq_fields: got fn=%b a=%h b=%h want fn=%b a=%h b=%h", bif.divreq_msg_fn,
                               bif.divreq_msg_a, bif.divreq_msg_b, !bif.req_msg_fn[0], bif.req_msg_a, bif.req_msg_b); end
      end
    end
    checks++; if (sent != N) begin failures++; $display("FAIL rnd_sent: got %0d want %0d", sent, N); end
    bif.req_val    = 1'b0;
    bif.divreq_rdy = 1'b1;
    bif.resp_rdy   = 1'b1;
    while (exp_q.size() > 0) begin
      get_resp(got, exp, ok);
      checks++; if (!ok || got !== exp) begin failures++; $display("FAIL rnd_resp: got %h want %h", got, exp); end
      if (!ok) break;
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++; if (obs_q.size() != 0 || bif.resp_val !== 1'b0) begin
      failures++; $display("FAIL rnd_extra: got %0d extra val=%b want 0/0", obs_q.size(), bif.resp_val); end
  endtask

  initial begin
    checks             = 0;
    failures           = 0;
    div_lat            = 3;
    dcyc               = 0;
    reset              = 1'b1;
    bif.req_val        = 1'b0;
    bif.req_msg_fn     = 2'd0;
    bif.req_msg_a      = 32'd0;
    bif.req_msg_b      = 32'd0;
    bif.divreq_rdy     = 1'b1;
    bif.resp_rdy       = 1'b1;
    bif.divresp_val    = 1'b0;
    bif.divresp_msg_result = 64'd0;
    test_reset();
    test_div_basic();
    test_bypass();
    test_order();
    test_full();
    test_stall();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imuldiv_div_frontend.md
# imuldiv_div_frontend

Request-side front end for the iterative integer divider. It accepts RISC-V style 32-bit DIV/DIVU/REM/REMU requests and forwards non-trivial ones to the divider as a signed/unsigned divide request. It resolves divide-by-zero locally and returns the selected 32-bit quotient or remainder in strict request order. It sits between the execute-stage issue logic and the divider's 64-bit {remainder, quotient} response.

## Interface
- DEPTH, 2, in-flight tracking FIFO entries; power of two, ≥2
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high
- req_val  in  1  upstream request valid
- req_rdy  out  1  upstream request ready
- req_msg_fn  in  2  operation: 0 DIV, 1 DIVU, 2 REM, 3 REMU
- req_msg_a  in  32  dividend
- req_msg_b  in  32  divisor
- divreq_val  out  1  divider request valid
- divreq_rdy  in  1  divider request ready
- divreq_msg_fn  out  1  1 = signed, 0 = unsigned
- divreq_msg_a  out  32  dividend, equal to req_msg_a
- divreq_msg_b  out  32  divisor, equal to req_msg_b
- divresp_val  in  1  divider response valid
- divresp_rdy  out  1  divider response ready
- divresp_msg_result  in  64  [63:32] remainder, [31:0] quotient
- resp_val  out  1  result valid
- resp_rdy  in  1  result ready
- resp_msg_result  out  32  selected result

## Operation
- Definitions:
  - bypass = (req_msg_b == 0).
  - signed = !req_msg_fn[0].
  - rem_sel = req_msg_fn[1].
- Each accepted request pushes a FIFO entry {bypass, rem_sel, data[31:0]}.
  - Bypass data: quotient 32'hFFFFFFFF for DIV/DIVU; remainder req_msg_a for REM/REMU.
  - Non-bypass data is don't-care.
- Accept condition, req_go = req_val && req_rdy:
  - req_rdy = !full && (bypass || divreq_rdy).
  - divreq_val = req_val && !full && !bypass.
  - Accepting a non-bypass request and firing the divider request are the same event.
- Response from FIFO head:
  - resp_val = !empty && (head.bypass || divresp_val).
  - divresp_rdy = !empty && !head.bypass && resp_rdy.
  - resp_msg_result:
    - head.data if head.bypass;
    - else divresp_msg_result[63:32] if head.rem_sel;
    - else divresp_msg_result[31:0].
  - Pop on resp_val && resp_rdy.
- Ordering: responses leave in acceptance order. A bypass entry behind a pending divide waits for that divide to complete.
- Signed overflow (−2^31 / −1) goes to the divider unmodified. The expected result is quotient 32'h80000000, remainder 0.
- Push and pop in the same cycle:
  - Occupancy is unchanged.
  - Allowed when non-full.
  - When full, push is blocked even if a pop occurs (no full pass-through).

## Timing
- Request path is combinational; no added cycle before the divider.
- Bypass result is visible at resp_val on the cycle after acceptance (minimum latency 1 cycle).
- Divide latency = divider latency. Response select and pop are combinational on divresp_val.
- Throughput:
  - Bypass requests: one per cycle until full.
  - Divides: limited by divreq_rdy.
- Reset:
  - Clears write pointer, read pointer and count.
  - Outputs while empty: resp_val = 0, divresp_rdy = 0.
  - req_rdy may assert the first cycle after reset.
  - Entries in flight are discarded. The divider is reset by the same reset, so no stale response appears.
- No output depends combinationally on resp_rdy, except divresp_rdy.

## Structure
- Shared package / include: fn encodings (IMULDIV_DIVFN_DIV/DIVU/REM/REMU) and divider signed-fn constant.
- Sub-module imuldiv_tag_fifo:
  - Parameterised width and DEPTH.
  - Pointers with wrap plus count.
  - Outputs full, empty, head data.
- The top level holds decode, bypass generation and the response mux.

## Test plan
- DIV 100/7 → divreq fn=1, a=100, b=7. Divider returns {2,14} → resp 14. Same operation as REM → resp 2.
- DIVU 32'hFFFFFFFE / 0 → no divreq_val. resp 32'hFFFFFFFF one cycle after acceptance. Same operands as REMU → resp 32'hFFFFFFFE.
- Ordering: DIV 9/3 (divider slow, 33 cycles), then REM 5/0. REM result 5 must wait. Outputs in order: 3, then 5.
- Fill with DEPTH bypass requests while resp_rdy = 0 → req_rdy drops at full. Raise resp_rdy → drains in order. Push and pop on the same cycle keep count constant.
- divreq_rdy = 0 with non-bypass request → req_rdy = 0, no push. Bypass request in the same condition is accepted.
- Reset asserted mid-divide → next cycle resp_val = 0, FIFO empty. A new DIVU 10/3 afterwards → resp 3.
